main_mem_arbiter: RTL and testbench
===================================

# main_mem_arbiter

Shares the single-port main memory between up to four requesters: instruction refill, scalar data refill, vector LSU, and debug/loader. The block grants one requester at a time with round-robin priority. It sequences one memory access per grant against the fixed-latency memory and routes the response back to the owner. It also keeps a saturating contention counter for performance runs. It sits in `soc` between the core-side refill/LSU ports and `u_main_memory`.

## Interface
- `NUM_REQ`, 3: number of requesters, 2..4
- `ADDR_W`, 32: byte address width
- `DATA_W`, 32: access data width
- `MEM_LAT`, 2: memory read latency in cycles from the `mem_en` cycle to valid `mem_rdata`, ≥1

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  request pending, per requester
- `req_ready`  out  NUM_REQ  grant/accept, per requester, one-hot or zero
- `req_we`  in  NUM_REQ  1 = write
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data
- `resp_valid`  out  NUM_REQ  one-cycle completion pulse to the owner
- `resp_rdata`  out  DATA_W  read data, shared bus, qualified by `resp_valid`
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  state ≠ IDLE
- `wait_cnt`  out  32  saturating count of cycles with ≥1 valid requester not accepted

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if any `req_valid`, pick winner g and assert `req_ready[g]` combinationally in the same cycle. Latch g, we, addr and wdata. Update the pointer to g. Go to ISSUE.
  - ISSUE: one cycle. `mem_en`=1; `mem_we`/`mem_addr`/`mem_wdata` come from the latched values. Go to WAIT. Load the latency counter with MEM_LAT-1.
  - WAIT: count down. When the counter is 0, capture `mem_rdata` into the response register (writes capture 0). Go to RESP.
  - RESP: `resp_valid[g]`=1 for exactly one cycle. Go to IDLE. No accept is allowed in RESP.
- Round-robin: priority begins at pointer+1 mod NUM_REQ and ascends with wrap. The reset pointer is NUM_REQ-1, so requester 0 has first priority.
- A requester must hold `req_valid` and its payload stable until `req_ready`. Dropping `req_valid` before the grant is allowed and is not an error.
- `req_ready` is never asserted outside IDLE.
- `wait_cnt` increments on every cycle where `|(req_valid & ~req_ready)`. It holds at 0xFFFF_FFFF.
- Reset, including mid-transaction, forces IDLE, clears the pointer to NUM_REQ-1 and clears `wait_cnt`. The in-flight access is dropped and no `resp_valid` is generated.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `wait_cnt`=0.
- Accept at cycle T, then:
  - `mem_en` at T+1
  - `mem_rdata` sampled at T+1+MEM_LAT
  - `resp_valid` at T+2+MEM_LAT
  - next accept possible at T+3+MEM_LAT
- Throughput: one access per MEM_LAT+3 cycles.
- Memory-side outputs are registered. `mem_addr`/`mem_wdata` hold their last values outside ISSUE; `mem_we` is 0 outside ISSUE.
- `req_ready` is the only combinational output; it depends on `req_valid` and state only.

## Structure
- `mem_arb_pkg`: state enum, `MEM_ARB_MAX_REQ`=4, `WAIT_CNT_W`=32.
- Sub-module `rr_arbiter`: combinational round-robin picker. Inputs: request vector and pointer. Outputs: one-hot grant and encoded index. The pointer register lives in the parent.

## Test plan
- Single read: only req 1 valid, addr 0x100, memory returns 0xDEAD_BEEF → `req_ready[1]` at T, `mem_en` at T+1 with addr 0x100, `resp_valid[1]` at T+4 (MEM_LAT=2) with `resp_rdata`=0xDEAD_BEEF.
- Contention: reqs 0, 1, 2 valid at the same time and held → grants in order 0, 1, 2 at T, T+5, T+10; `wait_cnt` advances by 1 on every cycle where any request is still waiting.
- Fairness: req 0 re-requests immediately after its response while req 2 is pending → req 2 is granted before req 0's second grant.
- Write then read: req 2 writes 0x1234_5678 to 0x40, then reads 0x40 → `mem_we`=1 only in the write's ISSUE cycle; the write's response has `resp_rdata`=0; the read returns 0x1234_5678.
- Reset in WAIT: assert `rst_n`=0 during WAIT → all outputs return to reset values immediately; no `resp_valid` appears; after release, req 0 wins a 3-way tie.
- Saturation: force `wait_cnt` near 0xFFFF_FFFF with long contention (or a bench-forced preload) → it holds at 0xFFFF_FFFF and does not wrap.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_ARB_MAX_REQ = 4;
    localparam int unsigned WAIT_CNT_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts at i_ptr+1 and wraps.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = cnt_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    int unsigned w_cand;
    logic        w_found;

    // First requester found after the pointer wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = (32'(i_ptr) + k) % N;
            if (!w_found && i_req[IDX_W'(w_cand)]) begin
                w_found                = 1'b1;
                o_gnt[IDX_W'(w_cand)]  = 1'b1;
                o_idx                  = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter sharing the single-port main memory between requesters.
module main_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy,
    output logic [WAIT_CNT_W-1:0]     wait_cnt
);

    localparam int unsigned IDX_W = cnt_width(NUM_REQ);
    localparam int unsigned LAT_W = cnt_width(MEM_LAT);

    if (NUM_REQ < 2 || NUM_REQ > MEM_ARB_MAX_REQ) begin : g_bad_num_req
        $error("main_mem_arbiter: NUM_REQ out of range");
    end

    arb_state_e          r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_we;
    logic [LAT_W-1:0]    r_lat;
    logic [NUM_REQ-1:0]  r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]    w_idx;
    logic                w_accept;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    // Grant is only offered in IDLE and never while reset is held.
    always_comb begin
        req_ready = (rst_n && r_state == ST_IDLE) ? w_gnt : '0;
        w_accept  = |req_ready;
    end

    // One-hot mux of the winner's payload.
    always_comb begin
        w_sel_we    = |(w_gnt & req_we);
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Access sequencer: accept, issue, wait out the latency, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= IDX_W'(NUM_REQ - 1);
            r_gnt        <= '0;
            r_we         <= 1'b0;
            r_lat        <= '0;
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_resp_valid <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gnt       <= w_gnt;
                        r_ptr       <= w_idx;
                        r_we        <= w_sel_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_lat   <= LAT_W'(MEM_LAT - 1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_lat == '0) begin
                        r_resp_rdata <= r_we ? '0 : mem_rdata;
                        r_resp_valid <= r_gnt;
                        r_state      <= ST_RESP;
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of cycles in which some valid request is left waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (|(req_valid & ~req_ready) && r_wait_cnt != '1) begin
            r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = (r_state != ST_IDLE);
    assign wait_cnt   = r_wait_cnt;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Scoreboard bench for main_mem_arbiter with a fixed-latency memory device.
module tb_main_mem_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_rdata;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      busy;
    logic [31:0]               wait_cnt;

    main_mem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .wait_cnt   (wait_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
    } op_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } memx_t;

    op_t         txq [NUM_REQ][$];
    resp_t       rq[$];
    memx_t       mq[$];
    logic [31:0] bmem    [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] pipe    [MEM_LAT];

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          ref_last = NUM_REQ - 1;
    int          next_acc = 0;
    logic [31:0] ref_wait = '0;
    logic [NUM_REQ-1:0] acc_vec = '0;
    int          gapc [NUM_REQ];
    logic        preload_pending = 1'b0;
    logic [31:0] preload_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] bmem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    // Round-robin rule: first valid requester after the last winner, wrapping.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (last + k) % NUM_REQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Memory device: reads appear MEM_LAT cycles after the strobe cycle.
    always @(posedge clk) begin
        for (int k = MEM_LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        if (mem_en && !mem_we) pipe[0] <= bmem_rd(mem_addr);
        else                   pipe[0] <= 32'h0BAD_0BAD;
        if (mem_en && mem_we) bmem[mem_addr] = mem_wdata;
    end
    assign mem_rdata = pipe[MEM_LAT-1];

    // Requester drivers: hold each op until accepted, then advance.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n) begin
                req_valid[i] = 1'b0;
            end else begin
                if (acc_vec[i] && req_valid[i]) begin
                    void'(txq[i].pop_front());
                    req_valid[i] = 1'b0;
                    gapc[i] = (txq[i].size() > 0) ? txq[i][0].gap : 0;
                end
                if (!req_valid[i] && txq[i].size() > 0) begin
                    if (gapc[i] > 0) gapc[i]--;
                    else begin
                        req_valid[i]                    = 1'b1;
                        req_we[i]                       = txq[i][0].we;
                        req_addr[i*ADDR_W +: ADDR_W]    = txq[i][0].addr;
                        req_wdata[i*DATA_W +: DATA_W]   = txq[i][0].wdata;
                    end
                end
                if (!req_valid[i]) begin
                    req_we[i]                     = 1'($urandom_range(0, 1));
                    req_addr[i*ADDR_W +: ADDR_W]  = $urandom;
                    req_wdata[i*DATA_W +: DATA_W] = $urandom;
                end
            end
        end
    end

    // Reference model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin : mon
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] oh;
        logic [31:0]        a;
        int                 w;
        resp_t              e;
        memx_t              m;
        cyc++;
        if (!rst_n) begin
            chk("rst_req_ready",  64'(req_ready), 64'(0));
            chk("rst_resp_valid", 64'(resp_valid), 64'(0));
            chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
            chk("rst_ctl",        64'({mem_en, mem_we, busy}), 64'(0));
            chk("rst_mem_addr",   64'(mem_addr), 64'(0));
            chk("rst_mem_wdata",  64'(mem_wdata), 64'(0));
            chk("rst_wait_cnt",   64'(wait_cnt), 64'(0));
            ref_last = NUM_REQ - 1;
            next_acc = 0;
            ref_wait = '0;
            rq.delete();
            mq.delete();
            acc_vec = '0;
        end else begin
            if (preload_pending) begin
                ref_wait        = preload_val;
                preload_pending = 1'b0;
            end
            chk("wait_cnt", 64'(wait_cnt), 64'(ref_wait));
            chk("busy", 64'(busy), 64'(cyc < next_acc));
            exp_ready = '0;
            w = -1;
            if (cyc >= next_acc && req_valid != '0) begin
                w = rr_pick(req_valid, ref_last);
                exp_ready[w] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            if (w >= 0) begin
                a      = req_addr[w*ADDR_W +: ADDR_W];
                e.idx  = w;
                e.cyc  = cyc + 2 + MEM_LAT;
                e.data = req_we[w] ? 32'h0 : ref_rd(a);
                if (req_we[w]) ref_mem[a] = req_wdata[w*DATA_W +: DATA_W];
                rq.push_back(e);
                m.we    = req_we[w];
                m.addr  = a;
                m.wdata = req_wdata[w*DATA_W +: DATA_W];
                m.cyc   = cyc + 1;
                mq.push_back(m);
                ref_last = w;
                next_acc = cyc + 3 + MEM_LAT;
            end
            if ((req_valid & ~exp_ready) != '0 && ref_wait != 32'hFFFF_FFFF) ref_wait++;
            acc_vec = req_ready;

            if (resp_valid != '0 || (rq.size() > 0 && rq[0].cyc <= cyc)) begin
                if (rq.size() == 0) chk("resp_spurious", 64'(resp_valid), 64'(0));
                else begin
                    e  = rq.pop_front();
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    chk("resp_valid", 64'(resp_valid), 64'(oh));
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("resp_rdata", 64'(resp_rdata), 64'(e.data));
                end
            end

            if (mem_en || (mq.size() > 0 && mq[0].cyc <= cyc)) begin
                if (mq.size() == 0) chk("mem_en_spurious", 64'(mem_en), 64'(0));
                else begin
                    m = mq.pop_front();
                    chk("mem_en",    64'(mem_en), 64'(1));
                    chk("mem_cycle", 64'(cyc), 64'(m.cyc));
                    chk("mem_we",    64'(mem_we), 64'(m.we));
                    chk("mem_addr",  64'(mem_addr), 64'(m.addr));
                    chk("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
                end
            end else begin
                chk("mem_we_idle", 64'(mem_we), 64'(0));
            end
        end
    end

    task automatic push_op(input int r, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int gap);
        op_t o;
        o.we = we; o.addr = addr; o.wdata = wdata; o.gap = gap;
        txq[r].push_back(o);
    endtask

    task automatic wait_idle(input int max_cyc);
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
            done = (req_valid == '0) && (rq.size() == 0) && (mq.size() == 0) && !busy;
            for (int i = 0; i < NUM_REQ; i++) if (txq[i].size() != 0) done = 1'b0;
        end
        chk("drain_timeout", 64'(done), 64'(1));
    endtask

    task automatic wait_busy(input int max_cyc);
        int n;
        n = 0;
        while (!busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", 64'(busy), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) gapc[i] = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // single read from requester 1
        bmem[32'h100]    = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        push_op(1, 1'b0, 32'h100, 32'h0, 0);
        wait_idle(50);

        // three-way contention
        for (int i = 0; i < NUM_REQ; i++) push_op(i, 1'b0, 32'h200 + 32'(i * 4), 32'h0, 0);
        wait_idle(60);

        // fairness: requester 0 re-requests while 2 is pending
        push_op(0, 1'b0, 32'h300, 32'h0, 0);
        push_op(0, 1'b0, 32'h304, 32'h0, 0);
        push_op(2, 1'b0, 32'h308, 32'h0, 0);
        wait_idle(60);

        // write then read back
        push_op(2, 1'b1, 32'h40, 32'h1234_5678, 0);
        push_op(2, 1'b0, 32'h40, 32'h0, 0);
        wait_idle(60);
        chk("wr_stored", 64'(bmem_rd(32'h40)), 64'(32'h1234_5678));

        // reset while waiting on memory
        push_op(1, 1'b0, 32'h500, 32'h0, 0);
        wait_busy(20);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_busy",     64'(busy), 64'(0));
        chk("async_mem_en",   64'(mem_en), 64'(0));
        chk("async_wait_cnt", 64'(wait_cnt), 64'(0));
        chk("async_resp",     64'(resp_valid), 64'(0));
        for (int i = 0; i < NUM_REQ; i++) push_op(i, 1'b0, 32'h600 + 32'(i * 4), 32'h0, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_idle(80);

        // randomized traffic over a small address window
        repeat (60) begin
            push_op(int'($urandom_range(0, NUM_REQ - 1)), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 15) * 4), $urandom, int'($urandom_range(0, 3)));
        end
        wait_idle(2000);

        // counter saturation under sustained contention
        for (int i = 0; i < NUM_REQ; i++)
            repeat (6) push_op(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom, 0);
        repeat (4) @(posedge clk);
        #2;
        force dut.r_wait_cnt = 32'hFFFF_FFFD;
        preload_val     = 32'hFFFF_FFFD;
        preload_pending = 1'b1;
        #5;
        release dut.r_wait_cnt;
        wait_idle(300);
        chk("wait_cnt_sat", 64'(wait_cnt), 64'(32'hFFFF_FFFF));

        chk("scoreboard_empty", 64'(rq.size() + mq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (%0d/%0d checks passed)", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
